// File: rtl/queen_count_display.sv
// rtl/queen_count_display.sv - 32-bit solution count to multiplexed 8-digit 7-segment display
//
// Captures an unsigned 32-bit count on a load request, converts it to ten BCD
// digits with an iterative double-dabble (one shift per clock), latches the low
// eight digits into a display register and scans them onto a common-anode
// 8-digit 7-segment display with leading-zero blanking and overflow dashes.
//
// Ports:
//   sysClk     in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset, clears all state
//   result     in  32   unsigned count from the solver
//   load       in   1   capture-and-convert request, honoured only when idle
//   busy       out  1   conversion in progress
//   bcd_valid  out  1   display register holds a completed conversion
//   bcd        out 32   displayed BCD digits, digit 0 in [3:0]
//   overflow   out  1   last converted value exceeded 99,999,999
//   segments   out  8   active-low {dp, g, f, e, d, c, b, a}; dp always off
//   anodes     out  8   active-low one-hot digit enable, [0] = least significant

module queen_count_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic        sysClk,
    input  logic        reset,
    input  logic [31:0] result,
    input  logic        load,
    output logic        busy,
    output logic        bcd_valid,
    output logic [31:0] bcd,
    output logic        overflow,
    output logic [7:0]  segments,
    output logic [7:0]  anodes
);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Registered state
    state_t                  state_q,     state_d;
    logic [31:0]             shift_q,     shift_d;
    logic [39:0]             acc_q,       acc_d;
    logic [4:0]              iter_q,      iter_d;
    logic                    busy_q,      busy_d;
    logic                    bcd_valid_q, bcd_valid_d;
    logic [31:0]             bcd_q,       bcd_d;
    logic                    overflow_q,  overflow_d;
    logic [REFRESH_BITS-1:0] scan_q,      scan_d;

    // Double-dabble step: add-3 correction followed by a one-bit left shift
    logic [39:0] acc_adj;
    logic [39:0] acc_shifted;

    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < 10; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end else begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4];
            end
        end
        acc_shifted = {acc_adj[38:0], shift_q[31]};
    end

    // Conversion FSM and display register
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        iter_d      = iter_q;
        busy_d      = busy_q;
        bcd_valid_d = bcd_valid_q;
        bcd_d       = bcd_q;
        overflow_d  = overflow_q;
        scan_d      = scan_q + REFRESH_BITS'(1);

        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = result;
                    acc_d   = '0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                acc_d   = acc_shifted;
                shift_d = {shift_q[30:0], 1'b0};
                iter_d  = iter_q + 5'd1;
                // iter_q == 31 means this edge performs the 32nd shift, so the
                // post-shift accumulator is the finished result.
                if (iter_q == 5'd31) begin
                    bcd_d       = acc_shifted[31:0];
                    overflow_d  = |acc_shifted[39:32];
                    bcd_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
            scan_q      <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            iter_q      <= iter_d;
            busy_q      <= busy_d;
            bcd_valid_q <= bcd_valid_d;
            bcd_q       <= bcd_d;
            overflow_q  <= overflow_d;
            scan_q      <= scan_d;
        end
    end

    assign busy      = busy_q;
    assign bcd_valid = bcd_valid_q;
    assign bcd       = bcd_q;
    assign overflow  = overflow_q;

    // Display scan: everything below is combinational from registered state,
    // so the anode and segment pattern always change together with scan_q.
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    logic [2:0] digit_idx;
    logic [3:0] digit_val;
    logic [7:0] zero_from;   // zero_from[i]: digits i..7 are all zero
    logic [6:0] seg_sel;

    assign digit_idx = scan_q[REFRESH_BITS-1 -: 3];
    assign digit_val = bcd_q[{digit_idx, 2'b00} +: 4];

    always_comb begin
        zero_from    = '0;
        zero_from[7] = (bcd_q[31:28] == 4'd0);
        for (int i = 6; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] & (bcd_q[i*4 +: 4] == 4'd0);
        end
    end

    always_comb begin
        seg_sel = seg_code(digit_val);
        if (overflow_q) begin
            seg_sel = SEG_DASH;
        end else if ((digit_idx != 3'd0) && zero_from[digit_idx]) begin
            seg_sel = SEG_BLANK;
        end
    end

    assign segments = {1'b1, seg_sel};
    assign anodes   = ~(8'd1 << digit_idx);

endmodule

// File: doc/queen_count_display.md
Name: queen_count_display

Overview:
- Downstream consumer of the N-Queens solver's 32-bit solution count.
- On a load pulse, captures the count and converts it to 10 BCD digits with an iterative double-dabble (one shift per clock).
- Latches the low 8 digits into a display register and drives a time-multiplexed 8-digit common-anode 7-segment display with leading-zero blanking and overflow indication.
- Replaces the raw byte-select output path used for board-level display.

Parameters:
- REFRESH_BITS, 16, width of the free-running scan counter; its top 3 bits select the active digit. Minimum 3. Benches use 4.

Ports:
- sysClk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- result  input  32  unsigned solution count from the solver.
- load  input  1  capture-and-convert request; sampled only in IDLE.
- busy  output  1  high while a conversion is in progress.
- bcd_valid  output  1  high once the display register holds a completed conversion; stays high until reset.
- bcd  output  32  displayed digits, 8 BCD nibbles; digit 0 in [3:0].
- overflow  output  1  last converted value exceeded 99,999,999.
- segments  output  8  active-low; [6:0] = g,f,e,d,c,b,a; [7] = dp, always 1.
- anodes  output  8  active-low, one-hot digit enable; [0] = least significant digit.

Behaviour:
- Reset values: busy=0, bcd_valid=0, bcd=0, overflow=0, scan counter=0, state=IDLE.
  - anodes=8'hFE and segments=8'hC0 (digit 0 showing "0") on the first cycle after reset.
- FSM states: IDLE, CONVERT.
- IDLE with load=1 at edge E0:
  - shift register <= result; 40-bit BCD accumulator <= 0; iteration count <= 0.
  - state <= CONVERT; busy <= 1.
- CONVERT, each edge:
  - Add 3 to every accumulator nibble >= 5.
  - Then shift {accumulator, shift register} left by 1; count++.
- 32nd shift occurs at edge E0+32. On that same edge:
  - bcd <= accumulator[31:0] (post-shift).
  - overflow <= |accumulator[39:32].
  - bcd_valid <= 1; busy <= 0; state <= IDLE.
- Latency: load sample to bcd_valid/bcd update = 32 cycles. A new load is accepted on the cycle after busy falls.
- load while busy is ignored; there is no queueing. result is sampled only at E0; later changes have no effect.
- bcd and overflow hold their previous values during conversion; the display never shows partial results.
- Reset mid-conversion aborts immediately to reset values; no display update occurs.
- Scan counter increments every cycle and wraps. Digit index d = counter[REFRESH_BITS-1 -: 3]; anodes = ~(1<<d).
- Segment codes, segments[6:0], hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F, dash=3F.
- Leading-zero blanking: digit d is blank if d>0 and all of digits d..7 are zero. Digit 0 is always shown.
- overflow=1: every digit shows dash (7'h3F) regardless of bcd.
- Segments and anodes are combinational from registered state. Both change on the same edge as the counter, so the digit/anode pair is always consistent.

Test Plan:
- Reset, result=92 (n=8), pulse load 1 cycle:
  - busy high for exactly 32 cycles; then bcd=32'h00000092, bcd_valid=1, overflow=0.
  - With REFRESH_BITS=4: anode 0 shows 0x24, anode 1 shows 0x10, digits 2–7 show 0x7F.
- result=0, load:
  - bcd=0; digit 0 shows 0x40; digits 1–7 blank.
- result=99999999, load:
  - bcd=32'h99999999, overflow=0, all 8 digits 0x10.
- result=100000000, load:
  - overflow=1; all digits 0x3F.
  - Then result=14200 (n=12), load: bcd=32'h00014200, overflow=0, digits 5–7 blank.
- result=92, load; at cycle 10 of busy set result=724 and pulse load:
  - Second load ignored; final bcd=32'h00000092.
  - A load after busy falls yields 32'h00000724.
- Conversion of 40 in progress; assert reset at cycle 15 of busy:
  - Next cycle: busy=0, bcd_valid=0, bcd=0, anodes=8'hFE.
  - No later update occurs without a new load.
